// File: rtl/pc_pkg.sv
// Shared types and default parameter values for the program-counter sequencer.
package pc_pkg;

   typedef enum logic [2:0] {
      SEL_HOLD,
      SEL_RET,
      SEL_CALL,
      SEL_ABS,
      SEL_REL,
      SEL_SEQ
   } sel_t;

   localparam int          PC_W_DEF      = 10;
   localparam int          STEP_DEF      = 4;
   localparam int          RAS_DEPTH_DEF = 4;
   localparam int unsigned RESET_PC_DEF  = 0;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push while full overwrites the oldest entry.
module pc_ras #(
   parameter int W     = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             push_data,
   output logic [W-1:0]             top,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] ptr_reg, ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             full_reg, empty_reg;

   // ptr_reg is the next free slot; once full it is also the oldest entry.
   always_comb begin
      ptr_next   = ptr_reg;
      count_next = count_reg;
      if (push) begin
         ptr_next = ptr_reg + 1'b1;
         if (count_reg != CNT_W'(DEPTH))
            count_next = count_reg + 1'b1;
      end else if (pop && count_reg != '0) begin
         ptr_next   = ptr_reg - 1'b1;
         count_next = count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_reg   <= '0;
         count_reg <= '0;
         full_reg  <= 1'b0;
         empty_reg <= 1'b1;
      end else begin
         ptr_reg   <= ptr_next;
         count_reg <= count_next;
         full_reg  <= (count_next == CNT_W'(DEPTH));
         empty_reg <= (count_next == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[ptr_reg] <= push_data;
   end

   assign top   = mem[ptr_reg - 1'b1];
   assign count = count_reg;
   assign full  = full_reg;
   assign empty = empty_reg;

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with call/return stack and sticky overflow/underflow flags.
// Optional target alignment check enabled by defining PC_ALIGN_CHK_EN.
module pc_seq
   import pc_pkg::*;
#(
   parameter int          PC_W      = PC_W_DEF,
   parameter int          STEP      = STEP_DEF,
   parameter int          RAS_DEPTH = RAS_DEPTH_DEF,
   parameter int unsigned RESET_PC  = RESET_PC_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            ret,
   input  logic            call,
   input  logic            branch_enable,
   input  logic            rel_enable,
   input  logic [PC_W-1:0] target,
   input  logic [PC_W-1:0] rel_off,
   output logic [PC_W-1:0] p_ct,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_ovf,
   output logic            ras_unf,
   output logic            misalign
);

   sel_t                      sel;
   logic [PC_W-1:0]           pc_reg, pc_next, raw_pc, seq_pc, ras_top;
   logic                      push, pop;
   logic                      ovf_reg, unf_reg, misalign_reg, misalign_next;
   logic [$clog2(RAS_DEPTH):0] ras_count;

   always_comb begin
      sel = SEL_SEQ;
      if (stall)              sel = SEL_HOLD;
      else if (ret)           sel = SEL_RET;
      else if (call)          sel = SEL_CALL;
      else if (branch_enable) sel = SEL_ABS;
      else if (rel_enable)    sel = SEL_REL;
   end

   assign seq_pc = pc_reg + PC_W'(STEP);

   // A return on an empty stack falls through to the sequential address.
   always_comb begin
      raw_pc = seq_pc;
      push   = 1'b0;
      pop    = 1'b0;
      case (sel)
         SEL_HOLD: raw_pc = pc_reg;
         SEL_RET: begin
            if (!ras_empty) begin
               raw_pc = ras_top;
               pop    = 1'b1;
            end
         end
         SEL_CALL: begin
            raw_pc = target;
            push   = 1'b1;
         end
         SEL_ABS: raw_pc = target;
         SEL_REL: raw_pc = pc_reg + rel_off;
         default: raw_pc = seq_pc;
      endcase
   end

`ifdef PC_ALIGN_CHK_EN
   localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(STEP - 1);
   logic checked;
   assign checked       = (sel == SEL_CALL) || (sel == SEL_ABS) || (sel == SEL_REL);
   assign pc_next       = checked ? (raw_pc & ~ALIGN_MASK) : raw_pc;
   assign misalign_next = checked && (|(raw_pc & ALIGN_MASK));
`else
   assign pc_next       = raw_pc;
   assign misalign_next = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg       <= PC_W'(RESET_PC);
         ovf_reg      <= 1'b0;
         unf_reg      <= 1'b0;
         misalign_reg <= 1'b0;
      end else begin
         pc_reg       <= pc_next;
         ovf_reg      <= ovf_reg | ((sel == SEL_CALL) && ras_full);
         unf_reg      <= unf_reg | ((sel == SEL_RET) && ras_empty);
         misalign_reg <= misalign_next;
      end
   end

   pc_ras #(
      .W     (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (seq_pc),
      .top       (ras_top),
      .count     (ras_count),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   assign p_ct     = pc_reg;
   assign ras_ovf  = ovf_reg;
   assign ras_unf  = unf_reg;
   assign misalign = misalign_reg;

endmodule

// File: tb/tb_pc_seq.sv
// Directed scoreboard bench for pc_seq; follows PC_ALIGN_CHK_EN for misalign expectations.
module tb_pc_seq;

   localparam int PC_W = 10;
`ifdef PC_ALIGN_CHK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset, stall, ret, call, branch_enable, rel_enable;
   logic [PC_W-1:0] target, rel_off;
   logic [PC_W-1:0] p_ct;
   logic            ras_empty, ras_full, ras_ovf, ras_unf, misalign;

   typedef struct {
      string           tag;
      logic [PC_W-1:0] pc;
      logic            empty, full, ovf, unf, mis;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pc_seq dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .ret           (ret),
      .call          (call),
      .branch_enable (branch_enable),
      .rel_enable    (rel_enable),
      .target        (target),
      .rel_off       (rel_off),
      .p_ct          (p_ct),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full),
      .ras_ovf       (ras_ovf),
      .ras_unf       (ras_unf),
      .misalign      (misalign)
   );

   task automatic chk(input string tag, input string field,
                      input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want)
      else begin
         errors++;
         $error("FAIL %s.%s got %h want %h", tag, field, got, want);
      end
   endtask

   // Drive one cycle of requests, queue the expectation, then compare after the edge.
   task automatic step(input string tag, input logic rs, st, rt, cl, br, rl,
                       input logic [PC_W-1:0] tg, ro, e_pc,
                       input logic e_empty, e_full, e_ovf, e_unf, e_mis);
      exp_t e, o;
      @(negedge clk);
      reset = rs; stall = st; ret = rt; call = cl;
      branch_enable = br; rel_enable = rl; target = tg; rel_off = ro;
      e.tag = tag; e.pc = e_pc; e.empty = e_empty; e.full = e_full;
      e.ovf = e_ovf; e.unf = e_unf; e.mis = e_mis;
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      $display("%-10s pc=%h empty=%b full=%b ovf=%b unf=%b mis=%b (want pc=%h)",
               o.tag, p_ct, ras_empty, ras_full, ras_ovf, ras_unf, misalign, o.pc);
      chk(o.tag, "pc",    32'(p_ct),      32'(o.pc));
      chk(o.tag, "empty", 32'(ras_empty), 32'(o.empty));
      chk(o.tag, "full",  32'(ras_full),  32'(o.full));
      chk(o.tag, "ovf",   32'(ras_ovf),   32'(o.ovf));
      chk(o.tag, "unf",   32'(ras_unf),   32'(o.unf));
      chk(o.tag, "mis",   32'(misalign),  32'(o.mis));
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; ret = 1'b0; call = 1'b0;
      branch_enable = 1'b0; rel_enable = 1'b0; target = '0; rel_off = '0;

      //    tag          rs st rt cl br rl target   rel_off  pc      emp ful ovf unf mis
      step("reset",      1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 10'h000, 1, 0, 0, 0, 0);
      step("seq1",       0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 10'h004, 1, 0, 0, 0, 0);
      step("seq2",       0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 10'h008, 1, 0, 0, 0, 0);
      step("seq3",       0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 10'h00C, 1, 0, 0, 0, 0);
      step("br_top",     0, 0, 0, 0, 1, 0, 10'h3FC, 10'h000, 10'h3FC, 1, 0, 0, 0, 0);
      step("wrap",       0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 10'h000, 1, 0, 0, 0, 0);
      step("br_010",     0, 0, 0, 0, 1, 1, 10'h010, 10'h3F8, 10'h010, 1, 0, 0, 0, 0);
      step("rel_neg",    0, 0, 0, 0, 0, 1, 10'h3A0, 10'h3F8, 10'h008, 1, 0, 0, 0, 0);
      step("br_020",     0, 0, 0, 0, 1, 0, 10'h020, 10'h000, 10'h020, 1, 0, 0, 0, 0);
      step("call100",    0, 0, 0, 1, 1, 0, 10'h100, 10'h000, 10'h100, 0, 0, 0, 0, 0);
      step("ret024",     0, 0, 1, 0, 0, 0, 10'h000, 10'h000, 10'h024, 1, 0, 0, 0, 0);
      // Five calls into a four-deep stack: the first return address (0x028) is lost.
      step("call_a",     0, 0, 0, 1, 0, 0, 10'h200, 10'h000, 10'h200, 0, 0, 0, 0, 0);
      step("call_b",     0, 0, 0, 1, 0, 0, 10'h210, 10'h000, 10'h210, 0, 0, 0, 0, 0);
      step("call_c",     0, 0, 0, 1, 0, 0, 10'h220, 10'h000, 10'h220, 0, 0, 0, 0, 0);
      step("call_d",     0, 0, 0, 1, 0, 0, 10'h230, 10'h000, 10'h230, 0, 1, 0, 0, 0);
      step("call_e",     0, 0, 0, 1, 0, 0, 10'h240, 10'h000, 10'h240, 0, 1, 1, 0, 0);
      step("stall1",     0, 1, 1, 1, 1, 1, 10'h3C0, 10'h010, 10'h240, 0, 1, 1, 0, 0);
      step("stall2",     0, 1, 1, 1, 1, 1, 10'h3C0, 10'h010, 10'h240, 0, 1, 1, 0, 0);
      step("stall3",     0, 1, 1, 1, 1, 1, 10'h3C0, 10'h010, 10'h240, 0, 1, 1, 0, 0);
      step("ret_e",      0, 0, 1, 0, 0, 0, 10'h000, 10'h000, 10'h234, 0, 0, 1, 0, 0);
      step("ret_d",      0, 0, 1, 0, 1, 0, 10'h3C0, 10'h000, 10'h224, 0, 0, 1, 0, 0);
      step("ret_c",      0, 0, 1, 0, 0, 0, 10'h000, 10'h000, 10'h214, 0, 0, 1, 0, 0);
      step("ret_b",      0, 0, 1, 0, 0, 0, 10'h000, 10'h000, 10'h204, 1, 0, 1, 0, 0);
      step("ret_unf",    0, 0, 1, 0, 0, 0, 10'h000, 10'h000, 10'h208, 1, 0, 1, 1, 0);
      step("call300",    0, 0, 0, 1, 0, 0, 10'h300, 10'h000, 10'h300, 0, 0, 1, 1, 0);
      step("callret",    0, 0, 1, 1, 0, 0, 10'h3A0, 10'h000, 10'h20C, 1, 0, 1, 1, 0);
      step("after_cr",   0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 10'h210, 1, 0, 1, 1, 0);
      step("br_mis",     0, 0, 0, 0, 1, 0, 10'h103, 10'h000,
           ALIGN ? 10'h100 : 10'h103, 1, 0, 1, 1, ALIGN);
      step("after_mis",  0, 0, 0, 0, 0, 0, 10'h000, 10'h000,
           ALIGN ? 10'h104 : 10'h107, 1, 0, 1, 1, 0);
      step("call050",    0, 0, 0, 1, 0, 0, 10'h050, 10'h000, 10'h050, 0, 0, 1, 1, 0);
      step("rst_mid",    1, 1, 1, 1, 1, 1, 10'h3C0, 10'h010, 10'h000, 1, 0, 0, 0, 0);
      step("ret_post",   0, 0, 1, 0, 0, 0, 10'h000, 10'h000, 10'h004, 1, 0, 0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout bench did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL expose parameters: PC_W, default 10, PC width in bits; STEP, default 4, sequential increment, power of two; RAS_DEPTH, default 4, return-stack entries, power of two, minimum 2; RESET_PC, default 0, value loaded on reset.
REQ-002 SHALL expose ports (name, direction, width, meaning):
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, synchronous, active-high.
- stall, input, 1, hold all state.
- ret, input, 1, pop RAS and jump to the popped address.
- call, input, 1, push p_ct+STEP and jump to target.
- branch_enable, input, 1, absolute jump to target.
- rel_enable, input, 1, relative jump by rel_off.
- target, input, PC_W, absolute target.
- rel_off, input, PC_W, two's-complement offset.
- p_ct, output, PC_W, current program counter.
- ras_empty, output, 1, RAS holds 0 entries.
- ras_full, output, 1, RAS holds RAS_DEPTH entries.
- ras_ovf, output, 1, sticky; a push occurred while full.
- ras_unf, output, 1, sticky; a pop occurred while empty.
- misalign, output, 1, one-cycle pulse; a non-sequential target was misaligned.

Function
REQ-003 SHALL apply per-cycle priority: reset > stall > ret > call > branch_enable > rel_enable > sequential.
REQ-004 SHALL update p_ct on the rising edge after the request is sampled (1-cycle latency); requests are level-sampled with no handshake.
REQ-005 Sequential: p_ct <= p_ct + STEP.
REQ-006 branch_enable: p_ct <= target.
REQ-007 rel_enable: p_ct <= p_ct + rel_off.
REQ-008 SHALL perform all PC arithmetic modulo 2^PC_W; wrap-around is silent (2^PC_W-STEP + STEP -> 0).
REQ-009 call: push p_ct+STEP (wrapped); p_ct <= target.
REQ-010 call when full: SHALL overwrite the oldest entry (circular), keep the count at RAS_DEPTH, and set ras_ovf.
REQ-011 ret when not empty: p_ct <= top entry; count decrements.
REQ-012 ret when empty: p_ct <= p_ct + STEP; count stays 0; ras_unf set.
REQ-013 stall: p_ct, RAS contents, count and sticky flags SHALL hold; all other requests that cycle are discarded.
REQ-014 Simultaneous call and ret: ret SHALL win and call is dropped; no push occurs.
REQ-015 Next-PC selector states: SEL_HOLD, SEL_RET, SEL_CALL, SEL_ABS, SEL_REL, SEL_SEQ; exactly one is active per cycle per REQ-003.
REQ-016 ras_empty/ras_full SHALL be registered, derived from the count, and valid in the same cycle as the count.

Reset
REQ-017 reset SHALL force p_ct=RESET_PC, count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0, misalign=0, overriding stall and all requests.
REQ-018 reset mid-sequence SHALL discard all RAS contents; RAS array storage need not be cleared.

Configuration
REQ-019 Macro PC_ALIGN_CHK_EN, when defined: SHALL force the low log2(STEP) bits of any SEL_CALL/SEL_ABS/SEL_REL next-PC to zero and pulse misalign for one cycle when any forced bit was nonzero.
REQ-020 Without PC_ALIGN_CHK_EN: targets SHALL be used verbatim and misalign SHALL be tied 0; the port list is unchanged.

Structure
REQ-021 Package pc_pkg SHALL hold the selector enum (REQ-015) and the default parameter constants.
REQ-022 RAS SHALL be a sub-module pc_ras (push, pop, top, count, full, empty; circular pointer); next-PC mux and sticky flags live in pc_seq.

Verification
REQ-023 reset, then 3 idle cycles -> p_ct sequence 0, 4, 8, 12.
REQ-024 p_ct=0x3FC, idle -> p_ct=0x000 (wrap); rel_enable with rel_off=0x3F8 (-8) at p_ct=0x010 -> 0x008.
REQ-025 call target=0x100 at p_ct=0x020, then ret -> p_ct 0x100, then 0x024; ras_empty=1 afterwards.
REQ-026 5 calls with RAS_DEPTH=4 -> ras_ovf=1, ras_full=1; 4 rets return the last 4 pushed addresses; a 5th ret -> ras_unf=1, p_ct advances by STEP.
REQ-027 stall=1 together with call and ret for 3 cycles -> p_ct, count and flags unchanged; call+ret together with a nonempty RAS -> pop only.
REQ-028 With PC_ALIGN_CHK_EN: branch_enable target=0x103 -> p_ct=0x100 and misalign high for 1 cycle; without the macro -> p_ct=0x103 and misalign=0.
